imem_arbiter: RTL
=================

# imem_arbiter

Two-port arbiter that shares the single combinational instruction-memory read port (11-bit word address, 32-bit instruction) between the CPU fetch stage and a debug/readback port. Each cycle it grants at most one requester, drives `mem_addr`, captures `mem_instr` into a per-port response register, and returns it with a one-cycle registered valid. Fetch has fixed priority. A saturating starvation counter guarantees the debug port a grant after a bounded wait. The block sits between the fetch stage or debug unit and the `imem` wrapper.

## Interface
Parameters:
- `ADDR_W`, 11: word address width; must match the `imem` address width.
- `DATA_W`, 32: instruction width.
- `STARVE_MAX`, 4: consecutive lost arbitration cycles after which debug is forced to win; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `f_req` input 1: fetch request; held high with `f_addr` stable until `f_gnt`.
- `f_addr` input ADDR_W: fetch word address.
- `f_gnt` output 1: combinational grant to fetch, this cycle.
- `f_rvalid` output 1: registered; high the cycle after `f_gnt`.
- `f_rdata` output DATA_W: registered instruction for the fetch port.
- `d_req` input 1: debug request; same hold rule as fetch.
- `d_addr` input ADDR_W: debug word address.
- `d_gnt` output 1: combinational grant to debug.
- `d_rvalid` output 1: registered response valid for debug.
- `d_rdata` output DATA_W: registered instruction for the debug port.
- `mem_addr` output ADDR_W: drives `imem.addr`.
- `mem_instr` input DATA_W: from `imem.instr`; combinational, valid in the same cycle.

## Operation
- Grant rule, evaluated each cycle:
  - `d_gnt = d_req & (~f_req | starve_cnt >= STARVE_MAX)`.
  - `f_gnt = f_req & ~d_gnt`.
  - `f_gnt` and `d_gnt` are never both high.
- `mem_addr` is the granted port's address. With no grant it holds its last registered value, which `last_addr` stores on every grant.
- Response capture: on a granted edge, `mem_instr` is written into the granted port's `*_rdata`, and `*_rvalid` is set for exactly one cycle. The other port's `rdata` is unchanged.
- Starvation counter, 4 bits, saturating at 15:
  - Reset to 0 on `d_gnt` or when `d_req` is low.
  - Otherwise incremented when `d_req & f_gnt`.
- Forced debug win: fetch sees `f_gnt` low for that cycle and must keep holding its request. No fetch request is dropped.
- Requests that drop before grant are simply ignored; no error is flagged.
- Back-to-back grants to the same port are allowed every cycle, giving full throughput of 1 read/cycle.

## Timing
- Reset value of every output: `f_gnt`, `d_gnt`, `f_rvalid`, `d_rvalid` = 0; `f_rdata`, `d_rdata` = 0; `mem_addr` = 0. Also `starve_cnt` = 0 and `last_addr` = 0.
- While `rst_n` is low, grants are forced to 0 regardless of requests.
- Latency: request granted in cycle N produces `rvalid` and data in cycle N+1. The only added latency is arbitration wait.
- Worst-case debug wait: STARVE_MAX cycles of continuous fetch. Debug is granted in the (STARVE_MAX+1)th cycle of its request.
- Reset asserted mid-transaction: a pending `rvalid` is cleared asynchronously and that response is lost. Requesters re-issue after reset.
- Simultaneous `f_req` and `d_req` with `starve_cnt` = 0: fetch wins and the counter becomes 1 at the edge.

## Structure
- Package `imem_pkg`: `ADDR_W`, `DATA_W`, `STARVE_MAX` default constants, and the `gnt_t` enum {GNT_NONE, GNT_FETCH, GNT_DEBUG} used for the internal registered-grant state.
- One sub-module, `imem_starve_ctr`: the saturating counter plus the `>= STARVE_MAX` compare output.
- Grant logic, address mux and response registers live in the top module.

## Test plan
- Reset: hold `rst_n` = 0 with both requests high → all outputs 0. Release reset with only `f_req`=1 and `f_addr`=0x010 → `f_gnt`=1 and `mem_addr`=0x010 that cycle. The next cycle has `f_rvalid`=1 with `f_rdata` equal to the model word at 0x010.
- Fetch streaming: addresses 0x000..0x007 on consecutive cycles → eight `f_rvalid` pulses back-to-back, data in order, no bubbles.
- Priority: `f_req` and `d_req` rise together, with `d_addr`=0x3FF and `STARVE_MAX`=4 → `f_gnt` for 4 cycles, `d_gnt` on cycle 5. `d_rdata` = word at 0x3FF on cycle 6, and `f_gnt` resumes on cycle 6.
- Idle hold: a single debug read at 0x155 followed by no requests → `mem_addr` stays 0x155 and both `rvalid` stay 0.
- Mid-transaction reset: assert `rst_n`=0 in the cycle after a grant → `f_rvalid` clears immediately and `starve_cnt` returns to 0.
- Mutual exclusion: random requests over 10k cycles → `f_gnt & d_gnt` never 1; no debug wait exceeds STARVE_MAX+1 cycles; every grant is followed by exactly one `rvalid`.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
// Defaults match the imem wrapper geometry.
package imem_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DEBUG
  } gnt_t;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of cycles debug lost arbitration to fetch.
// Flags when debug must be forced to win.
module imem_starve_ctr #(
  parameter int STARVE_MAX = imem_pkg::STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_req,
  input  logic d_gnt,
  input  logic f_gnt,
  output logic starved
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear when debug is idle or served; count fetch wins over it.
  always_comb begin
    cnt_d = cnt_q;
    if (!d_req || d_gnt) begin
      cnt_d = 4'd0;
    end else if (f_gnt && cnt_q != 4'hf) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (cnt_q >= 4'(STARVE_MAX));

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational imem read port between fetch and debug.
// Fetch has priority; debug is guaranteed a grant after a bounded wait.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = imem_pkg::ADDR_W,
  parameter int DATA_W     = imem_pkg::DATA_W,
  parameter int STARVE_MAX = imem_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_instr
);

  gnt_t              gnt_q;
  gnt_t              gnt_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] last_addr_d;
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] d_rdata_d;
  logic              starved;

  imem_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_req  (d_req),
    .d_gnt  (d_gnt),
    .f_gnt  (f_gnt),
    .starved(starved)
  );

  // Grants; reset masks them so nothing is granted in reset.
  always_comb begin
    d_gnt = rst_n & d_req & (~f_req | starved);
    f_gnt = rst_n & f_req & ~d_gnt;
  end

  // Address mux, grant record and response capture.
  always_comb begin
    mem_addr  = last_addr_q;
    gnt_d     = GNT_NONE;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (1'b1)
      d_gnt: begin
        mem_addr  = d_addr;
        gnt_d     = GNT_DEBUG;
        d_rdata_d = mem_instr;
      end
      f_gnt: begin
        mem_addr  = f_addr;
        gnt_d     = GNT_FETCH;
        f_rdata_d = mem_instr;
      end
      default: ;
    endcase
    last_addr_d = mem_addr;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= GNT_NONE;
      last_addr_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      gnt_q       <= gnt_d;
      last_addr_q <= last_addr_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign f_rvalid = (gnt_q == GNT_FETCH);
  assign d_rvalid = (gnt_q == GNT_DEBUG);
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
